// File: rtl/sensor_snapshot_regs.sv
// sensor_snapshot_regs
//
// This block holds NUM_CH sensor channels of CH_BYTES bytes each in live registers.
// A snapshot request copies the live registers into a shadow bank, together with a
// sequence number and a freshness mask. A burst read FSM then serves the shadow bank
// one byte at a time, incrementing the address after each accepted byte.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   ch_data, ch_valid        packed channel data and per-channel update strobes
//   snap_req                 snapshot request pulse
//   snap_busy                a snapshot is pending; it was deferred by an active burst
//   snap_ovr                 sticky flag: a request was coalesced into one already pending
//   rd_start, rd_addr        begin a burst at rd_addr
//   rd_next, rd_stop         advance the burst pointer or end the burst
//   rd_data, rd_valid        read byte, with a one-cycle latency
//   rd_err                   the current rd_data came from an address beyond the map
//
// Optional feature: define SNAP_TIMESTAMP_EN to add a free-running 32-bit cycle
// counter. Its value is captured at each snapshot and mapped after the freshness bytes.

module sensor_snapshot_regs #(
  parameter int unsigned NUM_CH   = 12,
  parameter int unsigned CH_BYTES = 2,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic                         snap_req,
  output logic                         snap_busy,
  output logic                         snap_ovr,
  input  logic                         rd_start,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic                         rd_next,
  input  logic                         rd_stop,
  output logic [7:0]                   rd_data,
  output logic                         rd_valid,
  output logic                         rd_err
);

  localparam int unsigned CH_W = CH_BYTES * 8;
  localparam int unsigned FB   = (NUM_CH + 7) / 8;
`ifdef SNAP_TIMESTAMP_EN
  localparam int unsigned TS_B = 4;
`else
  localparam int unsigned TS_B = 0;
`endif
  localparam int unsigned CH_BASE = FB + 1 + TS_B;
  localparam int unsigned LAST    = FB + TS_B + NUM_CH * CH_BYTES;
  localparam int unsigned MAP_LEN = LAST + 1;
  localparam logic [ADDR_W-1:0] LastA = ADDR_W'(LAST);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d, ptr_inc;
  logic               load;

  logic [CH_W-1:0]    live_q   [NUM_CH];
  logic [CH_W-1:0]    shadow_q [NUM_CH];
  logic [NUM_CH-1:0]  fresh_q, snap_fresh_q;
  logic [7:0]         seq_q;
  logic               pend_q, ovr_q, take_snap;
  logic [7:0]         rd_data_q;
  logic               rd_valid_q, rd_err_q;

  logic [FB*8-1:0]    fresh_pad;
  logic [7:0]         map [MAP_LEN];
  logic [7:0]         rd_byte;

`ifdef SNAP_TIMESTAMP_EN
  logic [31:0]        cnt_q, snap_ts_q;
`endif

  assign snap_busy = pend_q;
  assign snap_ovr  = ovr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;

  // A snapshot is taken only in an idle cycle with no rd_start, so the shadow never
  // changes during a burst and never races a load.
  assign take_snap = (state_q == StIdle) && !rd_start && (snap_req || pend_q);

  // Out-of-range pointers are never equal to LAST, so they increment with a plain wrap.
  assign ptr_inc = (ptr_q == LastA) ? '0 : ptr_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_start) begin
          state_d = StBurst;
          ptr_d   = rd_addr;
          load    = 1'b1;
        end
      end
      StBurst: begin
        if (rd_stop) begin
          state_d = StIdle;
        end else if (rd_start) begin
          ptr_d = rd_addr;
          load  = 1'b1;
        end else if (rd_next) begin
          ptr_d = ptr_inc;
          load  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign fresh_pad = (FB * 8)'(snap_fresh_q);

  // Flattened byte map of the shadow snapshot. Multi-byte fields are placed MSB first.
  always_comb begin
    for (int unsigned i = 0; i < MAP_LEN; i++) map[i] = '0;
    map[0] = seq_q;
    for (int unsigned k = 0; k < FB; k++) map[1 + k] = fresh_pad[(FB - 1 - k) * 8 +: 8];
`ifdef SNAP_TIMESTAMP_EN
    for (int unsigned k = 0; k < 4; k++) map[FB + 1 + k] = snap_ts_q[(3 - k) * 8 +: 8];
`endif
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned b = 0; b < CH_BYTES; b++) begin
        map[CH_BASE + c * CH_BYTES + b] = shadow_q[c][(CH_BYTES - 1 - b) * 8 +: 8];
      end
    end
  end

  // Addresses beyond LAST match no entry and read as 0x00.
  always_comb begin
    rd_byte = '0;
    for (int unsigned i = 0; i < MAP_LEN; i++) begin
      if (ptr_d == ADDR_W'(i)) rd_byte = map[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      fresh_q      <= '0;
      snap_fresh_q <= '0;
      seq_q        <= '0;
      pend_q       <= 1'b0;
      ovr_q        <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
`ifdef SNAP_TIMESTAMP_EN
      cnt_q     <= '0;
      snap_ts_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;

      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) live_q[i] <= ch_data[i * CH_W +: CH_W];
      end
      fresh_q <= fresh_q | ch_valid;

      if (take_snap) begin
        // Same-cycle updates bypass the live registers into the snapshot.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          shadow_q[i] <= ch_valid[i] ? ch_data[i * CH_W +: CH_W] : live_q[i];
        end
        snap_fresh_q <= fresh_q | ch_valid;
        fresh_q      <= '0;
        seq_q        <= seq_q + 8'd1;
      end

      pend_q <= take_snap ? 1'b0 : (pend_q | snap_req);
      if (snap_req && pend_q) ovr_q <= 1'b1;

      rd_valid_q <= load;
      if (load) begin
        rd_data_q <= rd_byte;
        rd_err_q  <= (ptr_d > LastA);
      end

`ifdef SNAP_TIMESTAMP_EN
      cnt_q <= cnt_q + 32'd1;
      if (take_snap) snap_ts_q <= cnt_q;
`endif
    end
  end

endmodule

// File: tb/tb_sensor_snapshot_regs.sv
module tb_sensor_snapshot_regs;

  localparam int unsigned NUM_CH   = 12;
  localparam int unsigned CH_BYTES = 2;
  localparam int unsigned ADDR_W   = 8;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_CH*CH_BYTES*8-1:0] ch_data;
  logic [NUM_CH-1:0]            ch_valid;
  logic                         snap_req;
  logic                         snap_busy;
  logic                         snap_ovr;
  logic                         rd_start;
  logic [ADDR_W-1:0]            rd_addr;
  logic                         rd_next;
  logic                         rd_stop;
  logic [7:0]                   rd_data;
  logic                         rd_valid;
  logic                         rd_err;

  int errors = 0;
  int checks = 0;

  sensor_snapshot_regs #(
    .NUM_CH  (NUM_CH),
    .CH_BYTES(CH_BYTES),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_data  (ch_data),
    .ch_valid (ch_valid),
    .snap_req (snap_req),
    .snap_busy(snap_busy),
    .snap_ovr (snap_ovr),
    .rd_start (rd_start),
    .rd_addr  (rd_addr),
    .rd_next  (rd_next),
    .rd_stop  (rd_stop),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [ADDR_W-1:0] a);
    rd_start = 1'b1;
    rd_addr  = a;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic nxt();
    rd_next = 1'b1;
    tick();
    rd_next = 1'b0;
  endtask

  // Expect a valid byte with the given error flag.
  task automatic expect_byte(input string tag, input logic [7:0] d, input logic e);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(d));
    chk({tag, "_err"}, 32'(rd_err), 32'(e));
  endtask

  initial begin
    rst      = 1'b1;
    ch_data  = '0;
    ch_valid = '0;
    snap_req = 1'b0;
    rd_start = 1'b0;
    rd_addr  = '0;
    rd_next  = 1'b0;
    rd_stop  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'h00);
    chk("rst_err", 32'(rd_err), 32'd0);
    chk("rst_busy", 32'(snap_busy), 32'd0);
    chk("rst_ovr", 32'(snap_ovr), 32'd0);

    // Update ch0, take a snapshot while idle, then read bytes 0..4
    ch_data[15:0] = 16'hA55A;
    ch_valid      = 12'h001;
    tick();
    ch_valid = '0;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("snap1_busy", 32'(snap_busy), 32'd0);
    start(8'd0);
    expect_byte("b0_seq", 8'h01, 1'b0);
    nxt();
    expect_byte("b1_freshhi", 8'h00, 1'b0);
    nxt();
    expect_byte("b2_freshlo", 8'h01, 1'b0);
    nxt();
    expect_byte("b3_ch0msb", 8'hA5, 1'b0);
    nxt();
    expect_byte("b4_ch0lsb", 8'h5A, 1'b0);
    tick();
    chk("hold_valid", 32'(rd_valid), 32'd0);
    chk("hold_data", 32'(rd_data), 32'h5A);

    // A snapshot requested during a burst is deferred; the shadow does not change
    ch_data[15:0]    = 16'hBEEF;
    ch_data[191:176] = 16'h7C3D;
    ch_valid         = 12'h801;
    snap_req         = 1'b1;
    tick();
    ch_valid = '0;
    snap_req = 1'b0;
    chk("defer_busy", 32'(snap_busy), 32'd1);
    chk("defer_ovr0", 32'(snap_ovr), 32'd0);
    start(8'd3);
    expect_byte("frozen_ch0", 8'hA5, 1'b0);
    start(8'd0);
    expect_byte("frozen_seq", 8'h01, 1'b0);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("coalesce_ovr", 32'(snap_ovr), 32'd1);
    chk("coalesce_busy", 32'(snap_busy), 32'd1);
    // When rd_stop and rd_start arrive together, rd_stop wins
    rd_stop  = 1'b1;
    rd_start = 1'b1;
    rd_addr  = 8'd5;
    tick();
    rd_stop  = 1'b0;
    rd_start = 1'b0;
    chk("stop_prio_valid", 32'(rd_valid), 32'd0);
    chk("stop_busy_still", 32'(snap_busy), 32'd1);
    tick();
    chk("idle_take_busy", 32'(snap_busy), 32'd0);
    start(8'd0);
    expect_byte("snap2_seq", 8'h02, 1'b0);
    nxt();
    expect_byte("snap2_freshhi", 8'h08, 1'b0);
    nxt();
    expect_byte("snap2_freshlo", 8'h01, 1'b0);
    nxt();
    expect_byte("snap2_ch0msb", 8'hBE, 1'b0);
    chk("ovr_sticky", 32'(snap_ovr), 32'd1);

    // Map boundaries: wrap at LAST and out-of-range addresses
    start(8'd25);
    expect_byte("ch11_msb", 8'h7C, 1'b0);
    nxt();
    expect_byte("ch11_lsb_last", 8'h3D, 1'b0);
    nxt();
    expect_byte("wrap_to_seq", 8'h02, 1'b0);
    start(8'd27);
    expect_byte("oor27", 8'h00, 1'b1);
    nxt();
    expect_byte("oor28", 8'h00, 1'b1);
    start(8'd255);
    expect_byte("oor255", 8'h00, 1'b1);
    nxt();
    expect_byte("wrap255_to0", 8'h02, 1'b0);
    rd_stop = 1'b1;
    tick();
    rd_stop = 1'b0;

    // rd_next is ignored while idle
    nxt();
    chk("idle_next_valid", 32'(rd_valid), 32'd0);

    // A same-cycle update of ch3 bypasses into the snapshot
    ch_data           = '0;
    ch_data[63:48]    = 16'h1234;
    ch_valid          = 12'h008;
    snap_req          = 1'b1;
    tick();
    ch_valid = '0;
    snap_req = 1'b0;
    chk("bypass_busy", 32'(snap_busy), 32'd0);
    start(8'd2);
    expect_byte("bypass_freshlo", 8'h08, 1'b0);
    start(8'd1);
    expect_byte("bypass_freshhi", 8'h00, 1'b0);
    start(8'd9);
    expect_byte("bypass_ch3msb", 8'h12, 1'b0);
    nxt();
    expect_byte("bypass_ch3lsb", 8'h34, 1'b0);
    start(8'd0);
    expect_byte("bypass_seq", 8'h03, 1'b0);
    rd_stop = 1'b1;
    tick();
    rd_stop  = 1'b0;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    start(8'd2);
    expect_byte("stale_freshlo", 8'h00, 1'b0);
    start(8'd0);
    expect_byte("stale_seq", 8'h04, 1'b0);

    // Reset during a burst with a snapshot pending
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("pre_rst_busy", 32'(snap_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_busy", 32'(snap_busy), 32'd0);
    chk("mid_rst_ovr", 32'(snap_ovr), 32'd0);
    chk("mid_rst_data", 32'(rd_data), 32'h00);
    tick();
    chk("post_rst_busy", 32'(snap_busy), 32'd0);
    start(8'd0);
    expect_byte("post_rst_seq", 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
